// File: rtl/buzzer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// buzzer_seq_ctrl
//   Square-wave note player for the speaker DAC path. Notes (half-period
//   divider, duration, volume, pan) arrive over a valid/ready handshake. One
//   note is held pending behind the playing note so melodies play without gaps.
//
//   Optional feature macro: BUZZ_SILENCE_EN
//     defined     : note_div == 0 plays a rest (PLAY state, audio held at 0)
//     not defined : note_div == 0 is a tone toggling phase every clk cycle
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   note_valid   note offered
//   note_ready   pending slot empty (accept = note_valid & note_ready)
//   note_div     half-period minus 1, in clk cycles
//   note_dur     duration in ticks, 0 = sustain until note_stop
//   note_vol     unsigned amplitude magnitude
//   note_pan     00 mute, 01 left, 10 right, 11 both
//   note_stop    abort the playing note (pending note kept)
//   busy         a note is playing
//   note_done    one-cycle pulse after a playing note ends or is stopped
//   audio_left   signed left sample
//   audio_right  signed right sample
// -----------------------------------------------------------------------------
module buzzer_seq_ctrl #(
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned DUR_W    = 16,
    parameter int unsigned AMP_W    = 16,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               note_valid,
    output logic               note_ready,
    input  logic [DIV_W-1:0]   note_div,
    input  logic [DUR_W-1:0]   note_dur,
    input  logic [AMP_W-2:0]   note_vol,
    input  logic [1:0]         note_pan,
    input  logic               note_stop,
    output logic               busy,
    output logic               note_done,
    output logic [AMP_W-1:0]   audio_left,
    output logic [AMP_W-1:0]   audio_right
);

    localparam int unsigned VOL_W    = AMP_W - 1;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TICK_MAX = TICK_DIV - 1;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic                ready_nxt, busy_nxt, done_nxt;

    logic [DIV_W-1:0]    pend_div, pend_div_nxt;
    logic [DUR_W-1:0]    pend_dur, pend_dur_nxt;
    logic [VOL_W-1:0]    pend_vol, pend_vol_nxt;
    logic [1:0]          pend_pan, pend_pan_nxt;

    logic [DIV_W-1:0]    act_div, act_div_nxt;
    logic [VOL_W-1:0]    act_vol, act_vol_nxt;
    logic [1:0]          act_pan, act_pan_nxt;

    logic [DIV_W-1:0]    clk_cnt, clk_cnt_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_cnt_nxt;
    logic [DUR_W-1:0]    dur_cnt, dur_cnt_nxt;
    logic                phase, phase_nxt;

    logic                tick_wrap, note_end, load, accept;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            note_ready <= 1'b1;
            busy       <= 1'b0;
            note_done  <= 1'b0;
            pend_div   <= '0;
            pend_dur   <= '0;
            pend_vol   <= '0;
            pend_pan   <= '0;
            act_div    <= '0;
            act_vol    <= '0;
            act_pan    <= '0;
            clk_cnt    <= '0;
            tick_cnt   <= '0;
            dur_cnt    <= '0;
            phase      <= 1'b0;
        end else begin
            state      <= state_nxt;
            note_ready <= ready_nxt;
            busy       <= busy_nxt;
            note_done  <= done_nxt;
            pend_div   <= pend_div_nxt;
            pend_dur   <= pend_dur_nxt;
            pend_vol   <= pend_vol_nxt;
            pend_pan   <= pend_pan_nxt;
            act_div    <= act_div_nxt;
            act_vol    <= act_vol_nxt;
            act_pan    <= act_pan_nxt;
            clk_cnt    <= clk_cnt_nxt;
            tick_cnt   <= tick_cnt_nxt;
            dur_cnt    <= dur_cnt_nxt;
            phase      <= phase_nxt;
        end
    end

    // Next-state, counters, pending/active note handling
    always_comb begin
        state_nxt    = state;
        ready_nxt    = note_ready;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        pend_div_nxt = pend_div;
        pend_dur_nxt = pend_dur;
        pend_vol_nxt = pend_vol;
        pend_pan_nxt = pend_pan;
        act_div_nxt  = act_div;
        act_vol_nxt  = act_vol;
        act_pan_nxt  = act_pan;
        clk_cnt_nxt  = clk_cnt;
        tick_cnt_nxt = tick_cnt;
        dur_cnt_nxt  = dur_cnt;
        phase_nxt    = phase;

        tick_wrap = (tick_cnt == TICK_W'(TICK_MAX));
        // A note ends on stop, or on the tick wrap that takes dur_cnt 1 -> 0
        note_end  = (state == PLAY) &&
                    (note_stop || (tick_wrap && (dur_cnt == DUR_W'(1))));
        load      = !note_ready && ((state == IDLE) || note_end);
        accept    = note_valid && note_ready;

        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            PLAY: begin
                if (note_end) begin
                    state_nxt    = IDLE;
                    clk_cnt_nxt  = '0;
                    tick_cnt_nxt = '0;
                    dur_cnt_nxt  = '0;
                    phase_nxt    = 1'b0;
                end else begin
                    if (clk_cnt == act_div) begin
                        clk_cnt_nxt = '0;
                        phase_nxt   = !phase;
                    end else begin
                        clk_cnt_nxt = clk_cnt + DIV_W'(1);
                    end
                    if (tick_wrap) begin
                        tick_cnt_nxt = '0;
                        // dur_cnt == 0 sustains; never wraps below zero
                        if (dur_cnt != '0) begin
                            dur_cnt_nxt = dur_cnt - DUR_W'(1);
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Pending note moves to active; overrides the end/idle handling above
        if (load) begin
            state_nxt    = PLAY;
            act_div_nxt  = pend_div;
            act_vol_nxt  = pend_vol;
            act_pan_nxt  = pend_pan;
            dur_cnt_nxt  = pend_dur;
            clk_cnt_nxt  = '0;
            tick_cnt_nxt = '0;
            phase_nxt    = 1'b0;
            ready_nxt    = 1'b1;
        end

        // Accept only happens with an empty slot, so it never collides with load
        if (accept) begin
            pend_div_nxt = note_div;
            pend_dur_nxt = note_dur;
            pend_vol_nxt = note_vol;
            pend_pan_nxt = note_pan;
            ready_nxt    = 1'b0;
        end

        done_nxt = note_end;
        busy_nxt = (state_nxt == PLAY);
    end

    logic [AMP_W-1:0] mag, wave;

    // Audio samples decoded from registered state
    always_comb begin
        mag  = {1'b0, act_vol};
        wave = phase ? mag : (~mag + AMP_W'(1));
        if (state != PLAY) begin
            wave = '0;
        end
`ifdef BUZZ_SILENCE_EN
        if (act_div == '0) begin
            wave = '0;
        end
`endif
        audio_left  = act_pan[0] ? wave : '0;
        audio_right = act_pan[1] ? wave : '0;
    end

endmodule

// File: tb/tb_buzzer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buzzer_seq_ctrl
//   Self-checking bench for buzzer_seq_ctrl. A note-level reference model
//   (elapsed cycles since load, phase from integer division, end from
//   dur*TICK_DIV) predicts every output each cycle. Directed scenarios run
//   first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_buzzer_seq_ctrl;

    localparam int unsigned DIV_W    = 22;
    localparam int unsigned DUR_W    = 16;
    localparam int unsigned AMP_W    = 16;
    localparam int unsigned TICK_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              note_valid = 1'b0;
    logic              note_ready;
    logic [DIV_W-1:0]  note_div = '0;
    logic [DUR_W-1:0]  note_dur = '0;
    logic [AMP_W-2:0]  note_vol = '0;
    logic [1:0]        note_pan = '0;
    logic              note_stop = 1'b0;
    logic              busy;
    logic              note_done;
    logic [AMP_W-1:0]  audio_left;
    logic [AMP_W-1:0]  audio_right;

    always #5 clk = ~clk;

    buzzer_seq_ctrl #(
        .DIV_W   (DIV_W),
        .DUR_W   (DUR_W),
        .AMP_W   (AMP_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_div   (note_div),
        .note_dur   (note_dur),
        .note_vol   (note_vol),
        .note_pan   (note_pan),
        .note_stop  (note_stop),
        .busy       (busy),
        .note_done  (note_done),
        .audio_left (audio_left),
        .audio_right(audio_right)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: playing note and one pending slot
    bit          m_known = 0;
    bit          m_busy  = 0;
    bit          m_done  = 0;
    int          m_k     = 0;
    int          m_div   = 0;
    int          m_dur   = 0;
    logic [14:0] m_vol   = '0;
    logic [1:0]  m_pan   = '0;
    bit          m_pend  = 0;
    int          p_div   = 0;
    int          p_dur   = 0;
    logic [14:0] p_vol   = '0;
    logic [1:0]  p_pan   = '0;

    // Observation counters for the directed windows
    int busy_seen = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_wave();
        logic [15:0] mag;
        if (!m_busy) return 16'h0000;
`ifdef BUZZ_SILENCE_EN
        if (m_div == 0) return 16'h0000;
`endif
        mag = {1'b0, m_vol};
        if (((m_k / (m_div + 1)) % 2) == 1) return mag;
        return 16'h0000 - mag;
    endfunction

    // One clock cycle: check current outputs, drive inputs, advance the model
    task automatic step(input bit v, input int div, input int dur,
                        input logic [14:0] vol, input logic [1:0] pan,
                        input bit stop, input bit rst);
        logic [15:0] w;
        bit ended, acc, ld;
        @(negedge clk);
        if (m_known) begin
            w = model_wave();
            check("note_ready", 32'(note_ready), 32'(!m_pend));
            check("busy", 32'(busy), 32'(m_busy));
            check("note_done", 32'(note_done), 32'(m_done));
            check("audio_left", 32'(audio_left), 32'(m_pan[0] ? w : 16'h0000));
            check("audio_right", 32'(audio_right), 32'(m_pan[1] ? w : 16'h0000));
        end
        if (busy === 1'b1) busy_seen++;
        if (note_done === 1'b1) done_seen++;

        rst_n      = rst;
        note_valid = v;
        note_div   = DIV_W'(div);
        note_dur   = DUR_W'(dur);
        note_vol   = vol;
        note_pan   = pan;
        note_stop  = stop;

        if (!rst) begin
            m_known = 1; m_busy = 0; m_pend = 0; m_done = 0; m_k = 0;
        end else if (m_known) begin
            ended  = m_busy && (stop || (m_dur != 0 && m_k + 1 == m_dur * int'(TICK_DIV)));
            acc    = v && !m_pend;
            ld     = m_pend && (!m_busy || ended);
            m_done = ended;
            if (ld) begin
                m_busy = 1; m_k = 0;
                m_div = p_div; m_dur = p_dur; m_vol = p_vol; m_pan = p_pan;
                m_pend = 0;
            end else if (ended) begin
                m_busy = 0;
            end else if (m_busy) begin
                m_k++;
            end
            if (acc) begin
                m_pend = 1; p_div = div; p_dur = dur; p_vol = vol; p_pan = pan;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 15'h0, 2'b00, 0, 1);
    endtask

    task automatic clear_window();
        @(negedge clk);
        busy_seen = 0;
        done_seen = 0;
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 15'h0, 2'b00, 0, 0);
        step(0, 0, 0, 15'h0, 2'b00, 0, 0);
        idle(2);

        // Single note: 3-cycle half period, 12 busy cycles, one done pulse
        busy_seen = 0; done_seen = 0;
        step(1, 2, 3, 15'h1000, 2'b11, 0, 1);
        idle(18);
        check("t2_busy_len", 32'(busy_seen), 32'd12);
        check("t2_done_cnt", 32'(done_seen), 32'd1);

        // Back-to-back notes: gap-free, two done pulses
        busy_seen = 0; done_seen = 0;
        step(1, 1, 2, 15'h0400, 2'b11, 0, 1);
        idle(1);
        step(1, 3, 1, 15'h0200, 2'b10, 0, 1);
        idle(30);
        check("t3_busy_len", 32'(busy_seen), 32'd12);
        check("t3_done_cnt", 32'(done_seen), 32'd2);

        // Sustained note stopped after 50 cycles
        busy_seen = 0; done_seen = 0;
        step(1, 4, 0, 15'h0123, 2'b11, 0, 1);
        idle(50);
        step(0, 0, 0, 15'h0, 2'b00, 1, 1);
        idle(4);
        check("t4_done_cnt", 32'(done_seen), 32'd1);

        // Stop with a pending note: pending loads instead
        step(1, 1, 0, 15'h0050, 2'b01, 0, 1);
        idle(3);
        step(1, 2, 1, 15'h0060, 2'b11, 0, 1);
        idle(5);
        step(0, 0, 0, 15'h0, 2'b00, 1, 1);
        idle(8);

        // Left-only full scale
        step(1, 1, 2, 15'h7FFF, 2'b01, 0, 1);
        idle(12);

        // div=0, dur=1: four busy cycles
        busy_seen = 0; done_seen = 0;
        step(1, 0, 1, 15'h0100, 2'b11, 0, 1);
        idle(8);
        check("t6_busy_len", 32'(busy_seen), 32'd4);
        check("t6_done_cnt", 32'(done_seen), 32'd1);

        // Reset mid-note for 3 cycles: no done pulse
        busy_seen = 0; done_seen = 0;
        step(1, 2, 5, 15'h0700, 2'b11, 0, 1);
        idle(6);
        step(0, 0, 0, 15'h0, 2'b00, 0, 0);
        step(0, 0, 0, 15'h0, 2'b00, 0, 0);
        step(0, 0, 0, 15'h0, 2'b00, 0, 0);
        idle(6);
        check("t1_done_cnt", 32'(done_seen), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0,
                 int'($urandom % 4),
                 int'($urandom % 4),
                 15'($urandom),
                 2'($urandom),
                 ($urandom % 30) == 0,
                 ($urandom % 400) != 0);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
